// File: rtl/magic_nor_sequencer.sv
`timescale 1ns/1ps
// magic_nor_sequencer: runs a stored NOR/NOT micro-op program over an emulated
// MAGIC memristor row of 1-bit cells. Each gate is a two-phase INIT/EVAL pair.
// Optional busy-cycle counter: define MAGIC_SEQ_CYCLE_CNT_EN to build it;
// otherwise cycle_cnt is tied to zero.
module magic_nor_sequencer #(
    parameter int unsigned NUM_CELLS  = 64,
    parameter int unsigned PROG_DEPTH = 64,
    parameter int unsigned CELL_AW    = 6,
    parameter int unsigned PC_W       = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   prog_we,
    input  logic [PC_W-1:0]        prog_addr,
    input  logic [2+3*CELL_AW-1:0] prog_data,
    input  logic                   start,
    input  logic [7:0]             x,
    input  logic [CELL_AW-1:0]     res_sel,
    output logic                   busy,
    output logic                   done,
    output logic                   z,
    output logic                   err,
    output logic [15:0]            cycle_cnt
);

    localparam int unsigned INSTR_W    = 2 + 3 * CELL_AW;
    localparam int unsigned CELL_SPACE = 1 << CELL_AW;

    localparam logic [1:0] OP_NOR  = 2'b00;
    localparam logic [1:0] OP_NOT  = 2'b01;
    localparam logic [1:0] OP_HALT = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_INIT  = 3'd3;
    localparam logic [2:0] S_EVAL  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [INSTR_W-1:0]    prog_mem [PROG_DEPTH];

    logic [2:0]            state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [CELL_SPACE-1:0] cell_q, cell_d;
    logic [7:0]            x_q, x_d;
    logic [CELL_AW-1:0]    sel_q, sel_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  z_q, z_d;
    logic                  err_q, err_d;

    logic [INSTR_W-1:0]    instr;
    logic [1:0]            op;
    logic [CELL_AW-1:0]    src_a, src_b, dst;
    logic                  opnd_a, opnd_b;
    logic                  pc_last;

    // Instruction decode; the program is frozen while busy so pc indexes it directly
    assign instr   = prog_mem[pc_q];
    assign op      = instr[INSTR_W-1 -: 2];
    assign src_a   = instr[3*CELL_AW-1 -: CELL_AW];
    assign src_b   = instr[2*CELL_AW-1 -: CELL_AW];
    assign dst     = instr[CELL_AW-1:0];
    assign opnd_a  = cell_q[src_a];
    assign opnd_b  = (op == OP_NOT) ? 1'b0 : cell_q[src_b];
    assign pc_last = (pc_q == PC_W'(PROG_DEPTH - 1));

    // Program memory: host writes accepted only while idle, never reset
    always_ff @(posedge clk) begin
        if (prog_we && (state_q == S_IDLE)) begin
            prog_mem[prog_addr] <= prog_data;
        end
    end

    // Next-state, cell update and registered-output logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cell_d  = cell_q;
        x_d     = x_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        z_d     = z_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = x;
                    sel_d   = res_sel;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cell_d      = '0;
                cell_d[7:0] = x_q;
                pc_d        = '0;
                state_d     = S_FETCH;
            end
            S_FETCH: begin
                case (op)
                    OP_NOR, OP_NOT: state_d = S_INIT;
                    OP_HALT: begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b0;
                    end
                    default: begin
                        if (pc_last) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                        end else begin
                            pc_d = pc_q + PC_W'(1);
                        end
                    end
                endcase
            end
            S_INIT: begin
                cell_d[dst] = 1'b1;
                state_d     = S_EVAL;
            end
            S_EVAL: begin
                // Conditional pull-down; a source aliased to dst was already set by INIT
                cell_d[dst] = cell_q[dst] & ~(opnd_a | opnd_b);
                if (pc_last) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Addresses beyond the physical row read as 0 and absorb writes
        for (int unsigned i = NUM_CELLS; i < CELL_SPACE; i++) begin
            cell_d[CELL_AW'(i)] = 1'b0;
        end

        // Result captured on entry to DONE so z is valid alongside done
        if (done_d) begin
            z_d = cell_d[sel_q];
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cell_q  <= '0;
            x_q     <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cell_q  <= cell_d;
            x_q     <= x_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

`ifdef MAGIC_SEQ_CYCLE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Busy-cycle counter: clears on accept, saturates, holds while idle
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == S_IDLE) && start) begin
            cnt_d = '0;
        end else if (busy_q && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_cnt = cnt_q;
`else
    assign cycle_cnt = '0;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign z    = z_q;
    assign err  = err_q;

endmodule
